aes_ctr_keystream: RTL

CTR-mode front end for the AES encipher datapath. It owns a 128-bit counter block and drives the encipher block's `next`/`block` inputs. It captures each enciphered counter as keystream and XORs it with incoming data blocks over a valid/ready stream. Key loading and `keylen` stay with the core controller; this block sits between the data stream and the encipher block.

---
 rtl/aes_ctr_keystream_pkg.sv | 19 +
 rtl/aes_ctr_keystream.sv | 87 ++++++++
 2 files changed

// File: rtl/aes_ctr_keystream_pkg.sv
// aes_ctr_keystream_pkg: FSM encodings, counter width default and counter increment
package aes_ctr_keystream_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_LOW  = 3'd2;
    localparam logic [2:0] WAIT_HIGH = 3'd3;
    localparam logic [2:0] HAVE_KS   = 3'd4;

    localparam int CTR_WIDTH_DEFAULT = 32;

    // Increments only the low w bits; carries out of that field are dropped.
    function automatic logic [127:0] ctr_inc(input logic [127:0] c, input int unsigned w);
        logic [127:0] m;
        m = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        return (c & ~m) | ((c + 128'd1) & m);
    endfunction

endpackage

// File: rtl/aes_ctr_keystream.sv
// aes_ctr_keystream: CTR-mode counter/keystream front end driving an AES encipher block
module aes_ctr_keystream
    import aes_ctr_keystream_pkg::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [127:0] ctr_iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         enc_next,
    output logic [127:0] enc_block,
    input  logic [127:0] enc_new_block,
    input  logic         enc_ready
);

    logic [2:0]   state;
    logic [127:0] ctr_reg;
    logic [127:0] ks_reg;
    logic         ks_valid;
    logic [127:0] out_data_reg;
    logic         out_valid_reg;
    logic         discard_reg;
    logic         transfer;

    assign in_ready  = ks_valid & (~out_valid_reg | out_ready);
    assign transfer  = in_valid & in_ready & ~init;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign enc_next  = state == START;
    assign enc_block = ctr_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ctr_reg       <= '0;
            ks_reg        <= '0;
            ks_valid      <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            discard_reg   <= 1'b0;
        end else if (init) begin
            ctr_reg       <= ctr_iv;
            ks_valid      <= 1'b0;
            out_valid_reg <= 1'b0;
            // A cipher run in flight cannot be aborted, so its result is flagged for dropping.
            if (state == WAIT_LOW || state == WAIT_HIGH)
                discard_reg <= 1'b1;
            else
                state <= START;
        end else begin
            if (transfer) begin
                out_data_reg  <= in_data ^ ks_reg;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state)
                START:    state <= WAIT_LOW;
                WAIT_LOW: state <= enc_ready ? WAIT_LOW : WAIT_HIGH;
                WAIT_HIGH: if (enc_ready) begin
                    if (discard_reg) begin
                        discard_reg <= 1'b0;
                        state       <= START;
                    end else begin
                        ks_reg   <= enc_new_block;
                        ks_valid <= 1'b1;
                        ctr_reg  <= ctr_inc(ctr_reg, CTR_WIDTH);
                        state    <= HAVE_KS;
                    end
                end
                HAVE_KS: if (transfer) begin
                    ks_valid <= 1'b0;
                    state    <= START;
                end
                default:  state <= state;
            endcase
        end
    end

endmodule
